// File: rtl/gpio_pkg.sv
// Shared constants for the memory-mapped GPIO port: default bus base address
// and the word offsets of every register in the map.
package gpio_pkg;

    localparam logic [31:0] GPIO_DEFAULT_BASE = 32'h0000_0400;

    localparam logic [31:0] GPIO_OUT        = 32'h0000_0000;
    localparam logic [31:0] GPIO_DIR        = 32'h0000_0004;
    localparam logic [31:0] GPIO_IN         = 32'h0000_0008;
    localparam logic [31:0] GPIO_SET        = 32'h0000_000C;
    localparam logic [31:0] GPIO_CLR        = 32'h0000_0010;
    localparam logic [31:0] GPIO_IRQ_EN     = 32'h0000_0014;
    localparam logic [31:0] GPIO_IRQ_EDGE   = 32'h0000_0018;
    localparam logic [31:0] GPIO_IRQ_STATUS = 32'h0000_001C;

endpackage

// File: rtl/gpio_sync_edge.sv
// Input synchroniser chain for the GPIO pins plus one cycle of history, giving
// the synchronised pin value and per-pin rise/fall pulses.
module gpio_sync_edge #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] in_val,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev;

    // Shift pins through the synchroniser; prev is cleared with the chain so
    // leaving reset can never look like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev <= '0;
        end else begin
            sync_q[0] <= pins;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign in_val = sync_q[SYNC_STAGES-1];
    assign rise   = in_val & ~prev;
    assign fall   = ~in_val & prev;

endmodule

// File: rtl/gpio_port.sv
// Memory-mapped GPIO peripheral: output/direction registers with atomic
// set/clear, synchronised input read-back and per-pin edge interrupts.
module gpio_port
    import gpio_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] BASE_ADDR   = GPIO_DEFAULT_BASE,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r_en,
    input  logic [31:0]      r_addr,
    output logic [31:0]      r_data,
    input  logic             w_en,
    input  logic [31:0]      w_addr,
    input  logic [31:0]      w_data,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] irq_en_q;
    logic [WIDTH-1:0] irq_edge_q;
    logic [WIDTH-1:0] irq_status_q;
    logic [WIDTH-1:0] in_val;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] status_clr;
    logic [31:0]      w_off;
    logic [31:0]      r_off;

    // Registers are only WIDTH bits wide; read-back pads the upper bits with 0.
    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        zext = 32'(v);
    endfunction

    gpio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .rst    (rst),
        .pins   (gpio_in),
        .in_val (in_val),
        .rise   (rise),
        .fall   (fall)
    );

    // Exact word decode: anything that is not BASE_ADDR+offset misses every case.
    assign w_off      = w_addr - BASE_ADDR;
    assign r_off      = r_addr - BASE_ADDR;
    assign wmask      = w_data[WIDTH-1:0];
    assign ev         = (irq_edge_q & rise) | (~irq_edge_q & fall);
    assign status_clr = (w_en && (w_off == GPIO_IRQ_STATUS)) ? wmask : '0;

    // Register file writes; status clears first so a same-cycle event wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            dir_q        <= '0;
            irq_en_q     <= '0;
            irq_edge_q   <= '0;
            irq_status_q <= '0;
        end else begin
            if (w_en) begin
                case (w_off)
                    GPIO_OUT:      out_q      <= wmask;
                    GPIO_DIR:      dir_q      <= wmask;
                    GPIO_SET:      out_q      <= out_q | wmask;
                    GPIO_CLR:      out_q      <= out_q & ~wmask;
                    GPIO_IRQ_EN:   irq_en_q   <= wmask;
                    GPIO_IRQ_EDGE: irq_edge_q <= wmask;
                    default:       ;
                endcase
            end
            irq_status_q <= (irq_status_q & ~status_clr) | ev;
        end
    end

    // Registered read mux; sees register values from before any same-cycle write.
    always_ff @(posedge clk) begin
        if (rst || !r_en) begin
            r_data <= '0;
        end else begin
            case (r_off)
                GPIO_OUT:        r_data <= zext(out_q);
                GPIO_DIR:        r_data <= zext(dir_q);
                GPIO_IN:         r_data <= zext(in_val);
                GPIO_IRQ_EN:     r_data <= zext(irq_en_q);
                GPIO_IRQ_EDGE:   r_data <= zext(irq_edge_q);
                GPIO_IRQ_STATUS: r_data <= zext(irq_status_q);
                default:         r_data <= '0;
            endcase
        end
    end

    // Combined interrupt, one cycle behind the status/enable registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |(irq_status_q & irq_en_q);
        end
    end

    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;

endmodule

// File: tb/tb_gpio_port.sv
// Bench for gpio_port: register table plus hand-built sequences for the
// synchroniser, interrupt and reset corner cases; reads go through a queue.
module tb_gpio_port;
    import gpio_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_en;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic        w_en;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oe;
    logic        irq;

    always #5 clk = ~clk;

    gpio_port #(
        .WIDTH       (8),
        .BASE_ADDR   (BASE),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .r_en     (r_en),
        .r_addr   (r_addr),
        .r_data   (r_data),
        .w_en     (w_en),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } rd_item_t;

    rd_item_t sb[$];
    rd_item_t mon_item;
    logic     rd_issued = 1'b0;

    typedef struct {
        logic [31:0] off;
        logic [31:0] wdata;
        logic [31:0] rexp;
        string       name;
    } vec_t;

    vec_t        tbl [9];
    logic [31:0] offs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Read data is valid the negedge after the edge that sampled r_en.
    always @(posedge clk) rd_issued <= r_en;

    always @(negedge clk) begin
        if (rd_issued) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got 0x%08h required no read", r_data);
            end else begin
                mon_item = sb.pop_front();
                check(mon_item.name, r_data, mon_item.exp);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        w_en   = 1'b1;
        w_addr = BASE + off;
        w_data = d;
        tick();
        w_en   = 1'b0;
    endtask

    task automatic rd_push(input logic [31:0] off, input logic [31:0] exp, input string name);
        rd_item_t it;
        r_en    = 1'b1;
        r_addr  = BASE + off;
        it.exp  = exp;
        it.name = name;
        sb.push_back(it);
    endtask

    task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string name);
        rd_push(off, exp, name);
        tick();
        r_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; r_en = 1'b0; r_addr = '0; w_en = 1'b0; w_addr = '0; w_data = '0;
        gpio_in = '0;

        tbl[0] = '{GPIO_OUT,        32'hFFFF_FF5A, 32'h0000_005A, "out_upper_ignored"};
        tbl[1] = '{GPIO_DIR,        32'h0000_01C3, 32'h0000_00C3, "dir_upper_ignored"};
        tbl[2] = '{GPIO_IRQ_EN,     32'h0000_01FF, 32'h0000_00FF, "irq_en_rw"};
        tbl[3] = '{GPIO_IRQ_EDGE,   32'h0000_00A5, 32'h0000_00A5, "irq_edge_rw"};
        tbl[4] = '{GPIO_IN,         32'h0000_0055, 32'h0000_0000, "in_read_only"};
        tbl[5] = '{GPIO_SET,        32'h0000_0000, 32'h0000_0000, "set_reads_zero"};
        tbl[6] = '{GPIO_CLR,        32'h0000_0000, 32'h0000_0000, "clr_reads_zero"};
        tbl[7] = '{32'h0000_0020,   32'h0000_00FF, 32'h0000_0000, "unmapped_reads_zero"};
        tbl[8] = '{32'h0000_0002,   32'h0000_00FF, 32'h0000_0000, "misaligned_reads_zero"};

        offs[0] = GPIO_OUT;    offs[1] = GPIO_DIR;      offs[2] = GPIO_IN;
        offs[3] = GPIO_SET;    offs[4] = GPIO_CLR;      offs[5] = GPIO_IRQ_EN;
        offs[6] = GPIO_IRQ_EDGE; offs[7] = GPIO_IRQ_STATUS;

        // Reset values
        repeat (2) tick();
        rst = 1'b0;
        check("rst_gpio_out", 32'(gpio_out), 32'h0);
        check("rst_gpio_oe", 32'(gpio_oe), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        for (int i = 0; i < 8; i++) rd(offs[i], 32'h0, "rst_read");

        // Basic read/write
        wr(GPIO_OUT, 32'hA5);
        check("gpio_out_a5", 32'(gpio_out), 32'hA5);
        wr(GPIO_DIR, 32'hF0);
        check("gpio_oe_f0", 32'(gpio_oe), 32'hF0);
        rd(GPIO_OUT, 32'hA5, "rd_out_a5");
        rd(GPIO_DIR, 32'hF0, "rd_dir_f0");

        // Register table
        for (int i = 0; i < 9; i++) begin
            wr(tbl[i].off, tbl[i].wdata);
            rd(tbl[i].off, tbl[i].rexp, tbl[i].name);
        end
        rd(GPIO_OUT, 32'h5A, "out_untouched_by_table");
        wr(GPIO_IRQ_EN, 32'h00);
        wr(GPIO_IRQ_EDGE, 32'h81);

        // Set / clear
        wr(GPIO_OUT, 32'h0F);
        wr(GPIO_SET, 32'h30);
        check("set_gpio_out", 32'(gpio_out), 32'h3F);
        wr(GPIO_CLR, 32'h05);
        check("clr_gpio_out", 32'(gpio_out), 32'h3A);
        rd(GPIO_OUT, 32'h3A, "rd_out_3a");

        // Same-cycle read and write return the old value
        rd_push(GPIO_OUT, 32'h3A, "rd_prewrite");
        w_en = 1'b1; w_addr = BASE + GPIO_OUT; w_data = 32'h11;
        tick();
        r_en = 1'b0; w_en = 1'b0;
        rd(GPIO_OUT, 32'h11, "rd_postwrite");

        // Synchroniser latency: pins change before edge k
        gpio_in = 8'h81;
        rd_push(GPIO_IN, 32'h00, "in_at_k");
        tick();
        rd_push(GPIO_IN, 32'h00, "in_at_k1");
        tick();
        rd_push(GPIO_IN, 32'h81, "in_after_k1");
        tick();
        r_en = 1'b0;
        rd(GPIO_IRQ_STATUS, 32'h81, "status_polled_no_en");
        check("irq_masked", 32'(irq), 32'h0);
        gpio_in = 8'h00;
        repeat (4) tick();
        rd(GPIO_IRQ_STATUS, 32'h81, "status_falls_ignored");
        wr(GPIO_IRQ_STATUS, 32'hFF);
        rd(GPIO_IRQ_STATUS, 32'h00, "status_w1c_all");

        // Rising-edge interrupt
        wr(GPIO_IRQ_EDGE, 32'h01);
        wr(GPIO_IRQ_EN, 32'h01);
        gpio_in = 8'h01;
        repeat (3) tick();
        check("irq_lags_status", 32'(irq), 32'h0);
        rd(GPIO_IRQ_STATUS, 32'h01, "status_rise");
        check("irq_rise", 32'(irq), 32'h1);
        wr(GPIO_IRQ_STATUS, 32'h01);
        check("irq_hold_after_w1c", 32'(irq), 32'h1);
        tick();
        check("irq_drop", 32'(irq), 32'h0);
        rd(GPIO_IRQ_STATUS, 32'h00, "status_cleared");
        gpio_in = 8'h00;
        repeat (4) tick();
        rd(GPIO_IRQ_STATUS, 32'h00, "fall_ignored_rise_mode");

        // Collision: W1C in the same cycle as a new event
        gpio_in = 8'h01;
        repeat (2) tick();
        w_en = 1'b1; w_addr = BASE + GPIO_IRQ_STATUS; w_data = 32'h01;
        tick();
        w_en = 1'b0;
        rd(GPIO_IRQ_STATUS, 32'h01, "collision_set_wins");
        wr(GPIO_IRQ_STATUS, 32'h01);
        rd(GPIO_IRQ_STATUS, 32'h00, "collision_cleanup");

        // Falling mode with interrupt disabled
        gpio_in = 8'h00;
        repeat (3) tick();
        wr(GPIO_IRQ_EN, 32'h00);
        wr(GPIO_IRQ_EDGE, 32'h00);
        gpio_in = 8'h01;
        repeat (4) tick();
        rd(GPIO_IRQ_STATUS, 32'h00, "rise_ignored_fall_mode");
        gpio_in = 8'h00;
        repeat (4) tick();
        rd(GPIO_IRQ_STATUS, 32'h01, "status_fall");
        check("irq_en_off", 32'(irq), 32'h0);
        wr(GPIO_IRQ_EN, 32'h01);
        check("irq_en_lag", 32'(irq), 32'h0);
        tick();
        check("irq_en_on", 32'(irq), 32'h1);
        wr(GPIO_IRQ_EN, 32'h00);
        tick();
        rd(GPIO_IRQ_STATUS, 32'h01, "en_keeps_status");
        check("irq_en_cleared", 32'(irq), 32'h0);

        // Reset mid-operation with pins high
        wr(GPIO_DIR, 32'h3C);
        gpio_in = 8'hFF;
        repeat (4) tick();
        rst = 1'b1;
        gpio_in = 8'h00;
        rd_push(GPIO_OUT, 32'h0, "read_during_reset");
        tick();
        r_en = 1'b0;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("rst2_gpio_out", 32'(gpio_out), 32'h0);
        check("rst2_gpio_oe", 32'(gpio_oe), 32'h0);
        check("rst2_irq", 32'(irq), 32'h0);
        rd(GPIO_IRQ_STATUS, 32'h0, "no_spurious_edge");
        rd(GPIO_IN, 32'h0, "rst2_in");
        rd(GPIO_IRQ_EN, 32'h0, "rst2_irq_en");

        repeat (2) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL read_queue_drained: got %0d pending required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpio_port.md
Name: gpio_port

Overview:
- Parametrised memory-mapped GPIO peripheral on the core's simple read/write bus, at base address 0x00000400. Successor to the fixed 8-bit output-only port.
- Provides per-pin direction control, synchronised input read-back, and atomic set/clear of output bits.
- Adds per-pin edge-detect interrupts with a single combined irq line to the core.

Parameters:
- WIDTH, 8, number of GPIO pins (1..32).
- BASE_ADDR, 32'h00000400, bus base address; decode is on exact word addresses BASE_ADDR+offset.
- SYNC_STAGES, 2, input synchroniser flops per pin (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- r_en  in  1  read enable.
- r_addr  in  32  read address.
- r_data  out  32  read data, registered.
- w_en  in  1  write enable.
- w_addr  in  32  write address.
- w_data  out->in  32  write data.
- gpio_in  in  WIDTH  asynchronous pin inputs.
- gpio_out  out  WIDTH  output values (OUT register).
- gpio_oe  out  WIDTH  output enables (DIR register, 1 = drive).
- irq  out  1  OR of (IRQ_STATUS & IRQ_EN), registered.

Behaviour:
- Single clock clk. Reset is synchronous and active-high on rst.
- On reset, these are all 0:
  - OUT, DIR, IRQ_EN, IRQ_EDGE, IRQ_STATUS;
  - synchroniser and edge-history flops;
  - r_data, irq, gpio_out, gpio_oe.
- Register map (offsets from BASE_ADDR). Bits above WIDTH read 0 and ignore writes.
  - 0x00 OUT: rw.
  - 0x04 DIR: rw.
  - 0x08 IN: ro, synchronised pin value.
  - 0x0C SET: wo, OUT <= OUT | w_data; reads 0.
  - 0x10 CLR: wo, OUT <= OUT & ~w_data; reads 0.
  - 0x14 IRQ_EN: rw.
  - 0x18 IRQ_EDGE: rw; 1 = rising, 0 = falling.
  - 0x1C IRQ_STATUS: rw1c; writing 1 clears a bit, writing 0 has no effect.
- Writes take effect on the clk edge where w_en=1. Writes to unmapped addresses or to IN are ignored.
- Reads:
  - r_en=1 at edge N gives r_data valid after edge N (1-cycle latency).
  - r_data = 0 when r_en=0 or the address is unmapped.
  - Read and write of the same register in one cycle return the pre-write value.
- Input path:
  - gpio_in passes through SYNC_STAGES flops; the IN register is the last stage.
  - A pin change seen before edge k appears in IN after edge k+SYNC_STAGES-1.
- Edge detect:
  - prev <= IN each cycle.
  - rise = IN & ~prev; fall = ~IN & prev.
  - ev[i] = IRQ_EDGE[i] ? rise[i] : fall[i].
  - IRQ_STATUS[i] sets on ev[i] regardless of IRQ_EN, so status can be polled.
- Simultaneous events:
  - ev[i]=1 and a W1C of bit i in the same cycle: set wins, bit stays 1.
  - SET and CLR target different addresses, so they never coincide.
  - A write to OUT replaces its whole value.
- irq <= |(IRQ_STATUS & IRQ_EN), one cycle after the status/enable update. Changing IRQ_EN never clears status.
- Output pins:
  - gpio_out reflects OUT regardless of DIR; external tri-state logic uses gpio_oe.
  - IN still samples pins configured as outputs (loop-back read).
- Reset mid-operation: all state returns to reset values on the next edge. A pending read returns 0 and there is no spurious edge event; prev is cleared together with IN.

Decomposition:
- Package gpio_pkg holds:
  - offset constants GPIO_OUT=0x00, GPIO_DIR=0x04, GPIO_IN=0x08, GPIO_SET=0x0C, GPIO_CLR=0x10, GPIO_IRQ_EN=0x14, GPIO_IRQ_EDGE=0x18, GPIO_IRQ_STATUS=0x1C;
  - the default base address.
- Sub-module gpio_sync_edge (parametrised on WIDTH and SYNC_STAGES) holds the synchroniser chain, prev register and rise/fall outputs. It has its own synchronous reset.
- Register file, address decode and irq logic live in gpio_port.

Test Plan:
- Reset values: assert rst 2 cycles, then read all 8 offsets -> every read returns 0x00000000; irq=0, gpio_out=0, gpio_oe=0.
- Read/write: write OUT=0xA5 and DIR=0xF0 -> gpio_out=0xA5 and gpio_oe=0xF0 the next cycle; read-backs return 0x000000A5 and 0x000000F0 one cycle after r_en. Write 0xFFFFFF5A to OUT -> reads 0x0000005A.
- Set/clear: OUT=0x0F, write SET=0x30 -> OUT=0x3F; write CLR=0x05 -> OUT=0x3A; reading SET or CLR -> 0.
- Synchroniser latency: drive gpio_in=0x81 before edge k -> IN reads 0x00 before edge k+1 and 0x81 after edge k+1 (SYNC_STAGES=2).
- Rising-edge irq: IRQ_EDGE=0x01, IRQ_EN=0x01, raise pin0 -> IRQ_STATUS=0x01, then irq=1 one cycle later. W1C 0x01 -> status 0 and irq drops the next cycle. A falling edge on pin0 -> no status change.
- Collision: W1C bit0 in the same cycle as a new pin0 rising event -> IRQ_STATUS[0] stays 1. Falling mode with IRQ_EN=0: status sets, irq stays 0. Then IRQ_EN=1 -> irq=1 one cycle later.
